// File: rtl/word_sequencer.sv
// rtl/word_sequencer.sv - word-index sequencer stepping an index over DEPTH words for PASSES passes
//
// Purpose:
//   A start pulse launches a sequence that steps index_o through 0..DEPTH-1
//   once per pass, for PASSES passes.
//   The sequencer supports stall (hold) and abort.
//   valid_o, busy_o and done_o are decoded from the state register.
//   last_o is decoded from the registered state and counters.
//   No input reaches any output combinationally.
//
// Optional feature macro: SEQ_RESTART_EN
//   When defined, start while running restarts the sequence at index 0 and pass 0.
//   When undefined, start is ignored while the sequencer is running.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   reset    in   synchronous, active-high reset
//   start    in   begin a sequence (level sampled each cycle)
//   hold     in   freeze index/pass this cycle
//   abort    in   return to IDLE without done
//   index_o  out  current word index (IDX_W)
//   pass_o   out  current pass number (PASS_W)
//   valid_o  out  index_o/pass_o address a live word
//   last_o   out  final word of final pass
//   busy_o   out  sequencer is running
//   done_o   out  one-cycle pulse after the final word

module word_sequencer #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int PASSES = 1,
    parameter int PASS_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic [IDX_W-1:0]  index_o,
    output logic [PASS_W-1:0] pass_o,
    output logic              valid_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W-1:0]    w_index_nxt;
    logic [PASS_W-1:0]   r_pass;
    logic [PASS_W-1:0]   w_pass_nxt;
    logic                w_restart;

`ifdef SEQ_RESTART_EN
    assign w_restart = start;
`else
    assign w_restart = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_pass  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Next-state logic.
    // Counters are cleared on every exit from RUN.
    // As a result, IDLE and DONE always present index 0 and pass 0.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_pass_nxt  = r_pass;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_index_nxt = '0;
            w_pass_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_state_nxt = start ? S_RUN : S_IDLE;
                    w_index_nxt = '0;
                    w_pass_nxt  = '0;
                end
                S_RUN: begin
                    if (w_restart) begin
                        // A restart takes priority over hold.
                        w_index_nxt = '0;
                        w_pass_nxt  = '0;
                    end else if (!hold) begin
                        // Wrap uses an explicit compare, so a DEPTH that is not a power of two works.
                        if (r_index != LAST_IDX) begin
                            w_index_nxt = r_index + IDX_W'(1);
                        end else if (r_pass != LAST_PASS) begin
                            w_index_nxt = '0;
                            w_pass_nxt  = r_pass + PASS_W'(1);
                        end else begin
                            w_index_nxt = '0;
                            w_pass_nxt  = '0;
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_index_nxt = '0;
                    w_pass_nxt  = '0;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        valid_o = (r_state == S_RUN);
        busy_o  = (r_state == S_RUN);
        done_o  = (r_state == S_DONE);
        last_o  = (r_state == S_RUN) && (r_index == LAST_IDX) && (r_pass == LAST_PASS);
        index_o = r_index;
        pass_o  = r_pass;
    end

endmodule

// File: tb/tb_word_sequencer.sv
// tb/tb_word_sequencer.sv - self-checking bench for word_sequencer

module tb_word_sequencer;

    logic clk;
    logic reset, start, hold, abort;

    logic [4:0] idx0;
    logic [2:0] pas0;
    logic       val0, lst0, bsy0, dn0;
    logic [3:0] idx1;
    logic [2:0] pas1;
    logic       val1, lst1, bsy1, dn1;

    word_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
        .index_o(idx0), .pass_o(pas0), .valid_o(val0), .last_o(lst0),
        .busy_o(bsy0), .done_o(dn0)
    );

    word_sequencer #(.DEPTH(16), .IDX_W(4), .PASSES(5), .PASS_W(3)) dut_mp (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
        .index_o(idx1), .pass_o(pas1), .valid_o(val1), .last_o(lst1),
        .busy_o(bsy1), .done_o(dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a single linear position within the sequence.
    // index = pos % DEPTH, pass = pos / DEPTH.
    int m_depth [2] = '{32, 16};
    int m_passes[2] = '{1, 5};
    int m_pos   [2] = '{0, 0};
    bit m_run   [2] = '{0, 0};
    bit m_done  [2] = '{0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit s, input bit h, input bit a, input bit r);
        for (int m = 0; m < 2; m++) begin
            int total;
            total = m_depth[m] * m_passes[m];
            if (r || a) begin
                m_run[m] = 0; m_done[m] = 0; m_pos[m] = 0;
            end else if (m_run[m]) begin
                if (s && RESTART) begin
                    m_pos[m] = 0;
                end else if (!h) begin
                    if (m_pos[m] == total - 1) begin
                        m_run[m] = 0; m_done[m] = 1; m_pos[m] = 0;
                    end else begin
                        m_pos[m]++;
                    end
                end
            end else begin
                m_done[m] = 0;
                m_pos[m]  = 0;
                m_run[m]  = s;
            end
        end
    endtask

    task automatic model_check();
        for (int m = 0; m < 2; m++) begin
            int e_idx, e_pass;
            bit e_last;
            int a_idx, a_pass, a_val, a_last, a_busy, a_done;
            e_idx  = m_pos[m] % m_depth[m];
            e_pass = m_pos[m] / m_depth[m];
            e_last = m_run[m] && (m_pos[m] == m_depth[m] * m_passes[m] - 1);
            if (m == 0) begin
                a_idx = int'(idx0); a_pass = int'(pas0); a_val = int'(val0);
                a_last = int'(lst0); a_busy = int'(bsy0); a_done = int'(dn0);
            end else begin
                a_idx = int'(idx1); a_pass = int'(pas1); a_val = int'(val1);
                a_last = int'(lst1); a_busy = int'(bsy1); a_done = int'(dn1);
            end
            chk($sformatf("model%0d_index", m), a_idx, e_idx);
            chk($sformatf("model%0d_pass", m), a_pass, e_pass);
            chk($sformatf("model%0d_valid", m), a_val, int'(m_run[m]));
            chk($sformatf("model%0d_busy", m), a_busy, int'(m_run[m]));
            chk($sformatf("model%0d_last", m), a_last, int'(e_last));
            chk($sformatf("model%0d_done", m), a_done, int'(m_done[m]));
        end
    endtask

    task automatic cycle(input bit s, input bit h, input bit a, input bit r);
        start = s; hold = h; abort = a; reset = r;
        @(posedge clk);
        #1;
        cyc++;
        model_step(s, h, a, r);
        model_check();
    endtask

    typedef struct {
        bit s, h, a, r;
        int n;
        int idx;
        bit valid, done, last, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit s, input bit h, input bit a, input bit r, input int n,
                                input int idx, input bit valid, input bit done, input bit last,
                                input bit busy);
        vec_t v;
        v.s = s; v.h = h; v.a = a; v.r = r; v.n = n;
        v.idx = idx; v.valid = valid; v.done = done; v.last = last; v.busy = busy;
        tbl.push_back(v);
    endfunction

    initial begin
        int lat, nvalid, maxpass;
        start = 0; hold = 0; abort = 0; reset = 1;

        //   s h a r  n   idx v d l b
        add(0,0,0,1,  5,  0, 0,0,0,0);   // reset state
        add(1,0,0,0,  1,  0, 1,0,0,1);   // start -> index 0
        add(0,0,0,0, 30, 30, 1,0,0,1);
        add(0,0,0,0,  1, 31, 1,0,1,1);   // last word
        add(0,0,0,0,  1,  0, 0,1,0,0);   // done pulse
        add(0,0,0,0,  1,  0, 0,0,0,0);   // back to idle
        add(1,0,0,0,  1,  0, 1,0,0,1);
        add(0,0,0,0, 10, 10, 1,0,0,1);
        add(0,1,0,0,  3, 10, 1,0,0,1);   // hold freezes index
        add(0,0,0,0,  1, 11, 1,0,0,1);
        add(0,0,0,0, 20, 31, 1,0,1,1);
        add(0,1,0,0,  1, 31, 1,0,1,1);   // last asserts under hold
        add(0,0,0,0,  1,  0, 0,1,0,0);
        add(1,0,0,0,  1,  0, 1,0,0,1);
        add(0,0,0,0,  7,  7, 1,0,0,1);
        add(0,0,1,0,  1,  0, 0,0,0,0);   // abort -> idle, no done
        add(1,0,1,0,  1,  0, 0,0,0,0);   // abort beats start
        add(1,0,0,0,  1,  0, 1,0,0,1);
        add(0,0,0,0, 12, 12, 1,0,0,1);
        add(1,0,0,0,  1, RESTART ? 0 : 13, 1,0,0,1);
        add(0,0,0,0,  1, RESTART ? 1 : 14, 1,0,0,1);
        add(0,0,0,1,  1,  0, 0,0,0,0);
        if (!RESTART) begin
            add(1,0,0,0,  1,  0, 1,0,0,1);   // start held: back-to-back runs
            add(1,0,0,0, 31, 31, 1,0,1,1);
            add(1,0,0,0,  1,  0, 0,1,0,0);
            add(1,0,0,0,  1,  0, 1,0,0,1);   // no dead cycle after done
            add(1,0,0,0, 20, 20, 1,0,0,1);
        end else begin
            add(1,0,0,0,  1,  0, 1,0,0,1);
            add(0,0,0,0, 20, 20, 1,0,0,1);
        end
        add(0,0,0,1,  1,  0, 0,0,0,0);   // reset mid-run at index 20

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].s, tbl[i].h, tbl[i].a, tbl[i].r);
            chk($sformatf("vec%0d_index", i), int'(idx0), tbl[i].idx);
            chk($sformatf("vec%0d_valid", i), int'(val0), int'(tbl[i].valid));
            chk($sformatf("vec%0d_done", i), int'(dn0), int'(tbl[i].done));
            chk($sformatf("vec%0d_last", i), int'(lst0), int'(tbl[i].last));
            chk($sformatf("vec%0d_busy", i), int'(bsy0), int'(tbl[i].busy));
        end

        // Multi-pass instance: 80 valid cycles, done 81 cycles after start.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        lat = 1; nvalid = 0; maxpass = 0;
        while (!dn1 && lat < 200) begin
            nvalid += int'(val1);
            if (int'(pas1) > maxpass) maxpass = int'(pas1);
            cycle(0, 0, 0, 0);
            lat++;
        end
        chk("mp_done_seen", int'(dn1), 1);
        chk("mp_latency", lat, 81);
        chk("mp_valid_count", nvalid, 80);
        chk("mp_max_pass", maxpass, 4);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 4000; i++) begin
            bit s, h, a, r;
            s = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 127) == 0);
            r = ($urandom_range(0, 511) == 0);
            cycle(s, h, a, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
